// File: rtl/oam_dma_pkg.sv
// Shared types and default addresses for the OAM DMA controller.
// The ALIGN state exists only when OAM_DMA_ALIGN_EN is defined.
package oam_dma_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  localparam logic [ADDR_W-1:0] DEFAULT_DMA_REG_ADDR  = 16'h4014;
  localparam logic [ADDR_W-1:0] DEFAULT_OAM_DATA_ADDR = 16'h2004;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_HALT_WAIT = 3'd1,
    S_DUMMY     = 3'd2,
`ifdef OAM_DMA_ALIGN_EN
    S_ALIGN     = 3'd3,
`endif
    S_READ      = 3'd4,
    S_WRITE     = 3'd5
  } state_t;

endpackage

// File: rtl/oam_dma_bus_mux.sv
// Combinational bus owner select: the CPU drives the bus unless DMA owns it.
module oam_dma_bus_mux
  import oam_dma_pkg::*;
(
  input  logic              i_own_bus,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic              i_cpu_rw,
  input  logic [DATA_W-1:0] i_cpu_data,
  input  logic [ADDR_W-1:0] i_dma_addr,
  input  logic              i_dma_rw,
  input  logic [DATA_W-1:0] i_dma_data,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic              o_bus_rw,
  output logic [DATA_W-1:0] o_bus_data
);

  always_comb begin
    o_bus_addr = i_cpu_addr;
    o_bus_rw   = i_cpu_rw;
    o_bus_data = i_cpu_data;
    if (i_own_bus) begin
      o_bus_addr = i_dma_addr;
      o_bus_rw   = i_dma_rw;
      o_bus_data = i_dma_data;
    end
  end

endmodule

// File: rtl/oam_dma_controller.sv
// OAM DMA: copies one 256-byte page to the OAM data port after a CPU write.
// Define OAM_DMA_ALIGN_EN to insert a parity-dependent ALIGN cycle.
module oam_dma_controller
  import oam_dma_pkg::*;
#(
  parameter logic [ADDR_W-1:0] DMA_REG_ADDR  = DEFAULT_DMA_REG_ADDR,
  parameter logic [ADDR_W-1:0] OAM_DATA_ADDR = DEFAULT_OAM_DATA_ADDR
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_rw,
  input  logic [DATA_W-1:0] cpu_data_out,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_rw,
  output logic [DATA_W-1:0] bus_data_out,
  output logic              cpu_halt,
  output logic              dma_busy,
  output logic              dma_done
);

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_page, w_page_nxt;
  logic [DATA_W-1:0] r_idx, w_idx_nxt;
  logic [DATA_W-1:0] r_data, w_data_nxt;
  logic              r_halt, w_halt_nxt;
  logic              r_done, w_done_nxt;
  logic              w_own_bus;
  logic [ADDR_W-1:0] w_dma_addr;
  logic              w_dma_rw;
`ifdef OAM_DMA_ALIGN_EN
  logic              r_parity;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_page  <= '0;
      r_idx   <= '0;
      r_data  <= '0;
      r_halt  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_page  <= w_page_nxt;
      r_idx   <= w_idx_nxt;
      r_data  <= w_data_nxt;
      r_halt  <= w_halt_nxt;
      r_done  <= w_done_nxt;
    end
  end

`ifdef OAM_DMA_ALIGN_EN
  // Free-running phase bit that decides whether an ALIGN cycle is needed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_parity <= 1'b0;
    else       r_parity <= ~r_parity;
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_page_nxt  = r_page;
    w_idx_nxt   = r_idx;
    w_data_nxt  = r_data;
    w_halt_nxt  = r_halt;
    w_done_nxt  = 1'b0;
    w_own_bus   = 1'b0;
    w_dma_addr  = {r_page, r_idx};
    w_dma_rw    = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (cpu_addr == DMA_REG_ADDR && !cpu_rw) begin
          w_page_nxt  = cpu_data_out;
          w_idx_nxt   = '0;
          w_halt_nxt  = 1'b1;
          w_state_nxt = S_HALT_WAIT;
        end
      end
      // CPU writes cannot be stalled; wait for its first read cycle.
      S_HALT_WAIT: if (cpu_rw) w_state_nxt = S_DUMMY;
      S_DUMMY: begin
`ifdef OAM_DMA_ALIGN_EN
        w_state_nxt = r_parity ? S_ALIGN : S_READ;
`else
        w_state_nxt = S_READ;
`endif
      end
`ifdef OAM_DMA_ALIGN_EN
      S_ALIGN: w_state_nxt = S_READ;
`endif
      S_READ: begin
        w_own_bus   = 1'b1;
        w_data_nxt  = mem_data_in;
        w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        w_own_bus  = 1'b1;
        w_dma_addr = OAM_DATA_ADDR;
        w_dma_rw   = 1'b0;
        if (r_idx == 8'hFF) begin
          w_halt_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_idx_nxt   = r_idx + 8'd1;
          w_state_nxt = S_READ;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign cpu_halt = r_halt;
  assign dma_done = r_done;
  assign dma_busy = (r_state != S_IDLE);

  oam_dma_bus_mux u_bus_mux (
    .i_own_bus  (w_own_bus),
    .i_cpu_addr (cpu_addr),
    .i_cpu_rw   (cpu_rw),
    .i_cpu_data (cpu_data_out),
    .i_dma_addr (w_dma_addr),
    .i_dma_rw   (w_dma_rw),
    .i_dma_data (r_data),
    .o_bus_addr (bus_addr),
    .o_bus_rw   (bus_rw),
    .o_bus_data (bus_data_out)
  );

endmodule

// File: tb/tb_oam_dma_controller.sv
// Directed self-checking bench for oam_dma_controller with a behavioural memory.
`timescale 1ns/1ps
module tb_oam_dma_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic        cpu_rw;
  logic [7:0]  cpu_data_out;
  logic [7:0]  mem_data_in;
  logic [15:0] bus_addr;
  logic        bus_rw;
  logic [7:0]  bus_data_out;
  logic        cpu_halt;
  logic        dma_busy;
  logic        dma_done;

  logic [7:0]  mem [0:65535];
  int          n_cmp  = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  int          par_cnt;

  always #5 clock = ~clock;

  oam_dma_controller dut (
    .clock        (clock),
    .reset        (reset),
    .cpu_addr     (cpu_addr),
    .cpu_rw       (cpu_rw),
    .cpu_data_out (cpu_data_out),
    .mem_data_in  (mem_data_in),
    .bus_addr     (bus_addr),
    .bus_rw       (bus_rw),
    .bus_data_out (bus_data_out),
    .cpu_halt     (cpu_halt),
    .dma_busy     (dma_busy),
    .dma_done     (dma_done)
  );

  assign mem_data_in = mem[bus_addr];

  always @(negedge clock) if (dma_done === 1'b1) done_cnt++;

  // Mirrors the free-running parity phase: posedges since reset release.
  always @(posedge clock or posedge reset) begin
    if (reset) par_cnt <= 0;
    else       par_cnt <= par_cnt + 1;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic transfer(input logic [7:0] page, input int nwr, input int abort_at);
    int   cyc;
    int   exp_cyc;
    int   d0;
    logic exp_align;
    logic [15:0] a;
    d0 = done_cnt;
    cpu_addr = 16'h4014; cpu_rw = 1'b0; cpu_data_out = page;
    #1 chk("trig_pass_addr", bus_addr, 16'h4014);
    tick();
    chk("hw_halt", 16'(cpu_halt), 16'h1);
    chk("hw_busy", 16'(dma_busy), 16'h1);
    for (int w = 0; w < nwr; w++) begin
      cpu_addr = 16'h4014; cpu_rw = 1'b0; cpu_data_out = 8'h55 ^ 8'(w);
      #1;
      chk("hw_wr_addr", bus_addr, 16'h4014);
      chk("hw_wr_rw", 16'(bus_rw), 16'h0);
      chk("hw_wr_data", 16'(bus_data_out), 16'(8'h55 ^ 8'(w)));
      tick();
      chk("hw_wr_busy", 16'(dma_busy), 16'h1);
      chk("hw_wr_halt", 16'(cpu_halt), 16'h1);
    end
    cpu_addr = 16'h8123; cpu_rw = 1'b1; cpu_data_out = 8'h3C;
    #1 chk("hw_rd_pass", bus_addr, 16'h8123);
    tick();
    chk("dummy_addr", bus_addr, 16'h8123);
    chk("dummy_rw", 16'(bus_rw), 16'h1);
`ifdef OAM_DMA_ALIGN_EN
    exp_align = par_cnt[0];
`else
    exp_align = 1'b0;
`endif
    exp_cyc = exp_align ? 514 : 513;
    cyc = 0;
    tick(); cyc++;
    if (exp_align) begin
      chk("align_addr", bus_addr, 16'h8123);
      tick(); cyc++;
    end
    for (int i = 0; i < 256; i++) begin
      a = {page, 8'(i)};
      chk("rd_addr", bus_addr, a);
      chk("rd_rw", 16'(bus_rw), 16'h1);
      tick(); cyc++;
      chk("wr_addr", bus_addr, 16'h2004);
      chk("wr_rw", 16'(bus_rw), 16'h0);
      chk("wr_data", 16'(bus_data_out), 16'(mem[a]));
      chk("wr_nodone", 16'(dma_done), 16'h0);
      if (i == abort_at) begin
        reset = 1'b1;
        #1;
        chk("rst_halt", 16'(cpu_halt), 16'h0);
        chk("rst_busy", 16'(dma_busy), 16'h0);
        chk("rst_done", 16'(dma_done), 16'h0);
        chk("rst_addr", bus_addr, cpu_addr);
        chk("rst_rw", 16'(bus_rw), 16'(cpu_rw));
        chk("rst_data", 16'(bus_data_out), 16'(cpu_data_out));
        tick();
        chk("rst_hold_busy", 16'(dma_busy), 16'h0);
        reset = 1'b0;
        tick();
        chk("rst_no_pulse", 16'(done_cnt - d0), 16'h0);
        return;
      end
      tick(); cyc++;
    end
    chk("end_busy", 16'(dma_busy), 16'h0);
    chk("end_halt", 16'(cpu_halt), 16'h0);
    chk("end_done", 16'(dma_done), 16'h1);
    chk("end_cycles", 16'(cyc), 16'(exp_cyc));
    chk("end_pass", bus_addr, 16'h8123);
    tick();
    chk("done_pulse_clr", 16'(dma_done), 16'h0);
    chk("done_once", 16'(done_cnt - d0), 16'h1);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h02;
    reset = 1'b1; cpu_addr = 16'h0100; cpu_rw = 1'b1; cpu_data_out = 8'h00;
    repeat (3) @(posedge clock);
    #2;
    chk("reset_halt", 16'(cpu_halt), 16'h0);
    chk("reset_busy", 16'(dma_busy), 16'h0);
    chk("reset_done", 16'(dma_done), 16'h0);
    chk("reset_addr", bus_addr, 16'h0100);
    reset = 1'b0;
    tick();
    cpu_addr = 16'h4014; cpu_rw = 1'b1; cpu_data_out = 8'h02;
    tick();
    chk("read_no_trig", 16'(dma_busy), 16'h0);

    transfer(8'h02, 0, -1);
    transfer(8'h02, 2, -1);
    tick();
    transfer(8'hFF, 0, -1);
    transfer(8'h02, 1, 8'h80);
    transfer(8'h02, 0, -1);
    chk("total_done", 16'(done_cnt), 16'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/oam_dma_controller.md
OAM_DMA_CONTROLLER -- requirements
Module: oam_dma_controller

Interface
REQ-001 SHALL have parameter DMA_REG_ADDR, default 16'h4014, the CPU write address that triggers DMA.
REQ-002 SHALL have parameter OAM_DATA_ADDR, default 16'h2004, the destination address of every DMA write.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state updates on posedge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port cpu_addr, input, 16 bits: the CPU address bus.
REQ-006 SHALL have port cpu_rw, input, 1 bit: CPU read/write (1 = read, 0 = write).
REQ-007 SHALL have port cpu_data_out, input, 8 bits: CPU write data.
REQ-008 SHALL have port mem_data_in, input, 8 bits: memory read data, valid by the posedge ending a read cycle.
REQ-009 SHALL have port bus_addr, output, 16 bits: the address driven to memory.
REQ-010 SHALL have port bus_rw, output, 1 bit: the read/write strobe driven to memory.
REQ-011 SHALL have port bus_data_out, output, 8 bits: the write data driven to memory.
REQ-012 SHALL have port cpu_halt, output, 1 bit: registered; 1 requests that the CPU stall.
REQ-013 SHALL have port dma_busy, output, 1 bit: 1 in any state other than IDLE.
REQ-014 SHALL have port dma_done, output, 1 bit: a one-cycle pulse after the final transfer.

Function
REQ-015 SHALL use states IDLE, HALT_WAIT, DUMMY, ALIGN, READ and WRITE.
REQ-016 In IDLE, a cycle with cpu_addr==DMA_REG_ADDR and cpu_rw==0 SHALL latch page=cpu_data_out, clear idx to 0, set cpu_halt and go to HALT_WAIT.
REQ-017 In HALT_WAIT, the block SHALL stay while cpu_rw==0 (writes are not stallable) and SHALL go to DUMMY on the first cycle with cpu_rw==1.
REQ-018 DUMMY SHALL last one cycle, during which the halted CPU's read owns the bus.
REQ-019 On leaving DUMMY, if alignment is enabled and the parity bit is 1, the block SHALL go to ALIGN for one cycle; otherwise it SHALL go to READ.
REQ-020 A free-running parity bit SHALL toggle every clock.
REQ-021 In READ, outputs SHALL be bus_addr={page,idx} and bus_rw=1, and mem_data_in SHALL be latched into a data register at the end of the cycle.
REQ-022 In WRITE, outputs SHALL be bus_addr=OAM_DATA_ADDR, bus_rw=0 and bus_data_out=latched data.
REQ-023 After WRITE, if idx==8'hFF the block SHALL go to IDLE; otherwise idx SHALL increment and the block SHALL go to READ.
REQ-024 idx SHALL be 8 bits; there SHALL be no carry into page, so addresses never cross the page.
REQ-025 Exactly 256 READ/WRITE pairs SHALL occur per trigger.
REQ-026 cpu_halt SHALL clear and dma_done SHALL pulse on the cycle IDLE is re-entered.
REQ-027 In states other than READ and WRITE, the bus outputs SHALL pass cpu_addr, cpu_rw and cpu_data_out through.
REQ-028 A write to DMA_REG_ADDR while dma_busy==1 SHALL be ignored.
REQ-029 Cycle count from the first DUMMY cycle to the return to IDLE SHALL be 513 (even parity) or 514 (odd parity, alignment enabled).

Reset
REQ-030 While reset is asserted, at any time including mid-transfer, the block SHALL enter IDLE with cpu_halt=0, dma_busy=0, dma_done=0, idx=0, page=0, data=0 and parity=0, and the bus SHALL be returned to the CPU immediately.

Configuration
REQ-031 With macro OAM_DMA_ALIGN_EN defined, the ALIGN state SHALL be compiled in and used per REQ-019.
REQ-032 Without OAM_DMA_ALIGN_EN, ALIGN and the parity bit SHALL be absent, and DUMMY SHALL always go to READ (fixed 513 cycles).

Structure
REQ-033 Package oam_dma_pkg SHALL hold the state enum typedef and the default addresses 16'h4014 and 16'h2004.
REQ-034 The bus multiplexer SHALL be sub-module oam_dma_bus_mux (combinational; selects CPU or DMA drive from an own_bus signal).

Verification
REQ-035 Write $02 to $4014 with page $02 preloaded 00..FF -> 256 writes to $2004 carrying values 00..FF in order; dma_done pulses once.
REQ-036 Trigger followed by two CPU write cycles -> HALT_WAIT holds for 2 cycles; DUMMY starts on the first read; no bus takeover during the writes.
REQ-037 OAM_DMA_ALIGN_EN defined, trigger on odd and even parity -> 514 and 513 cycles from DUMMY to IDLE respectively.
REQ-038 Page $FF, idx reaching $FF -> last read at $FFFF, then IDLE; no access to $0000.
REQ-039 Reset asserted at idx=$80 during WRITE -> immediate IDLE, cpu_halt=0, bus outputs equal the CPU inputs; a retrigger then transfers the full 256 bytes.
